// File: rtl/mips_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_seq_pkg
// Shared definitions for the multi-cycle MIPS sequencer: FSM state encoding,
// halt-cause codes, instruction field positions and the PC increment.
// -----------------------------------------------------------------------------
package mips_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_DECODE  = 2'd1,
        CAUSE_TIMEOUT = 2'd2
    } halt_cause_e;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    localparam logic [31:0] PC_INCR = 32'd4;

    function automatic logic [5:0] inst_opcode(input logic [31:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic [5:0] inst_funct(input logic [31:0] word);
        return word[FUNCT_MSB:FUNCT_LSB];
    endfunction

endpackage

// File: rtl/mips_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// mips_seq_ctrl_if
// Instruction-memory request/acknowledge port between the sequencer and memory.
//   imem_req   : fetch request (sequencer -> memory)
//   imem_addr  : fetch address, 32 bits (sequencer -> memory)
//   imem_ack   : fetch data valid this cycle (memory -> sequencer)
//   imem_rdata : instruction word, 32 bits (memory -> sequencer)
// -----------------------------------------------------------------------------
interface mips_seq_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/mips_seq_ctrl_fetch_watchdog.sv
// -----------------------------------------------------------------------------
// fetch_watchdog
// 8-bit down-counter bounding the number of FETCH cycles spent waiting for an
// acknowledge. Clear reloads LIMIT-1; each enabled cycle decrements, stopping
// at zero. terminal_o is high while the count is zero, i.e. during the
// LIMIT-th counted cycle.
// Ports:
//   clock_i    : clock
//   reset_i    : synchronous active-low reset
//   clear_i    : reload the counter
//   enable_i   : count this cycle
//   terminal_o : limit reached
// -----------------------------------------------------------------------------
module fetch_watchdog #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic terminal_o
);

    localparam logic [7:0] LOAD = 8'(LIMIT - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = LOAD;
        end else if (enable_i && (count_q != 8'd0)) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            count_q <= LOAD;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal_o = (count_q == 8'd0);

endmodule

// File: rtl/mips_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mips_seq_ctrl
// Multi-cycle sequencer for the single-issue MIPS ALU datapath. Fetches an
// instruction over the imem port, holds it in the instruction register that
// feeds the external decoder, then steps DECODE -> EXECUTE -> WRITEBACK.
// Owns the PC, the retired-instruction count and the halt state.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | waiting for run_i
// FETCH      | imem_req high, waiting for imem_ack (watchdog running)
// DECODE     | decoder reads inst_o; sample dec_except_i / dec_writeenable_i
// EXECUTE    | alu_stage_o high
// WRITEBACK  | rf_wr_en_o = we_q, retired_o high, pc/instret advance
// HALT       | sticky; only reset leaves
//
// Ports:
//   clock_i, reset_i         : clock, synchronous active-low reset
//   run_i                    : checked in IDLE and WRITEBACK only
//   imem                     : instruction-memory port (master side)
//   inst_o                   : instruction register
//   dec_writeenable_i        : decoder write enable for inst_o
//   dec_except_i             : decoder illegal-instruction flag
//   alu_stage_o              : EXECUTE strobe
//   rf_wr_en_o, retired_o    : WRITEBACK strobes
//   pc_o, instret_o          : PC and retired count
//   halted_o, halt_cause_o   : halt flag and cause (0 none, 1 decode, 2 timeout)
// -----------------------------------------------------------------------------
module mips_seq_ctrl
    import mips_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0040_0000,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 run_i,
    mips_seq_ctrl_if.master      imem,
    output logic [31:0]          inst_o,
    input  logic                 dec_writeenable_i,
    input  logic                 dec_except_i,
    output logic                 alu_stage_o,
    output logic                 rf_wr_en_o,
    output logic                 retired_o,
    output logic [31:0]          pc_o,
    output logic [31:0]          instret_o,
    output logic                 halted_o,
    output logic [1:0]           halt_cause_o
);

    state_e      state_q,   state_d;
    logic [31:0] pc_q,      pc_d;
    logic [31:0] inst_q,    inst_d;
    logic [31:0] instret_q, instret_d;
    logic        we_q,      we_d;
    halt_cause_e cause_q,   cause_d;

    logic wd_clear;
    logic wd_enable;
    logic wd_terminal;

    // The watchdog only counts inside FETCH; any other state reloads it so
    // every fetch starts with the full budget.
    assign wd_clear  = (state_q != ST_FETCH);
    assign wd_enable = (state_q == ST_FETCH) && !imem.imem_ack;

    fetch_watchdog #(
        .LIMIT (FETCH_TIMEOUT)
    ) u_fetch_watchdog (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .clear_i    (wd_clear),
        .enable_i   (wd_enable),
        .terminal_o (wd_terminal)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        instret_d = instret_q;
        we_d      = we_q;
        cause_d   = cause_q;

        case (state_q)
            ST_IDLE: begin
                if (run_i) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Ack takes priority over a watchdog expiring in the same cycle.
                if (imem.imem_ack) begin
                    inst_d  = imem.imem_rdata;
                    state_d = ST_DECODE;
                end else if (wd_terminal) begin
                    cause_d = CAUSE_TIMEOUT;
                    state_d = ST_HALT;
                end
            end
            ST_DECODE: begin
                if (dec_except_i) begin
                    cause_d = CAUSE_DECODE;
                    state_d = ST_HALT;
                end else begin
                    we_d    = dec_writeenable_i;
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                state_d = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                pc_d      = pc_q + PC_INCR;
                instret_d = instret_q + 32'd1;
                state_d   = run_i ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= 32'd0;
            instret_q <= 32'd0;
            we_q      <= 1'b0;
            cause_q   <= CAUSE_NONE;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            instret_q <= instret_d;
            we_q      <= we_d;
            cause_q   <= cause_d;
        end
    end

    // Strobes depend only on registered state, so they cannot glitch.
    assign imem.imem_req  = (state_q == ST_FETCH);
    assign imem.imem_addr = pc_q;
    assign alu_stage_o    = (state_q == ST_EXECUTE);
    assign rf_wr_en_o     = (state_q == ST_WRITEBACK) && we_q;
    assign retired_o      = (state_q == ST_WRITEBACK);
    assign halted_o       = (state_q == ST_HALT);

    assign inst_o       = inst_q;
    assign pc_o         = pc_q;
    assign instret_o    = instret_q;
    assign halt_cause_o = cause_q;

endmodule

// File: tb/tb_mips_seq_ctrl.sv
module tb_mips_seq_ctrl;
    import mips_seq_pkg::*;

    localparam logic [31:0] PC0   = 32'h0040_0000;
    localparam logic [31:0] PC0_B = 32'hFFFF_FFFC;
    localparam logic [31:0] OFF_B = PC0_B - PC0;
    localparam int          TMO   = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0;
    logic dec_we = 1'b0;
    logic dec_exc = 1'b0;

    mips_seq_ctrl_if mem1();
    mips_seq_ctrl_if mem2();

    // Second instance runs in lockstep on the same stimulus, starting at the
    // top of the address space to exercise PC wrap.
    assign mem2.imem_ack   = mem1.imem_ack;
    assign mem2.imem_rdata = mem1.imem_rdata;

    logic [31:0] inst1, pc1, instret1, inst2, pc2, instret2;
    logic        alu1, wr1, ret1, halted1, alu2, wr2, ret2, halted2;
    logic [1:0]  cause1, cause2;

    mips_seq_ctrl #(.RESET_PC(PC0), .FETCH_TIMEOUT(TMO)) dut (
        .clock_i(clk), .reset_i(rst_n), .run_i(run), .imem(mem1),
        .inst_o(inst1), .dec_writeenable_i(dec_we), .dec_except_i(dec_exc),
        .alu_stage_o(alu1), .rf_wr_en_o(wr1), .retired_o(ret1),
        .pc_o(pc1), .instret_o(instret1), .halted_o(halted1), .halt_cause_o(cause1)
    );

    mips_seq_ctrl #(.RESET_PC(PC0_B), .FETCH_TIMEOUT(TMO)) dut_b (
        .clock_i(clk), .reset_i(rst_n), .run_i(run), .imem(mem2),
        .inst_o(inst2), .dec_writeenable_i(dec_we), .dec_except_i(dec_exc),
        .alu_stage_o(alu2), .rf_wr_en_o(wr2), .retired_o(ret2),
        .pc_o(pc2), .instret_o(instret2), .halted_o(halted2), .halt_cause_o(cause2)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    typedef struct {
        int          waits;
        logic [31:0] word;
        logic        we;
        logic        exc;
        logic        run_next;
        logic        exp_wr;
        logic [1:0]  exp_cause;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; dec_we = 1'b0; dec_exc = 1'b0;
        mem1.imem_ack = 1'b0; mem1.imem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_pc", pc1, PC0);
        chk("rst_pc_b", pc2, PC0_B);
        chk("rst_inst", inst1, 32'd0);
        chk("rst_instret", instret1, 32'd0);
        chk("rst_cause", 32'(cause1), 32'd0);
        chk("rst_halted", 32'({halted1, halted2}), 32'd0);
        chk("rst_strobes", 32'({mem1.imem_req, alu1, wr1, ret1}), 32'd0);
        rst_n = 1'b1; run = 1'b1;
        m_pc = PC0; m_cnt = 32'd0;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (mem1.imem_req !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(mem1.imem_req), 32'd1);
    endtask

    task automatic do_instr(input int waits, input logic [31:0] word, input logic we,
                            input logic exc, input logic run_next, input logic exp_wr,
                            input logic [1:0] exp_cause);
        run = 1'b1;
        wait_req("fetch_req");
        if (mem1.imem_req !== 1'b1) return;
        for (int i = 0; i < waits; i++) begin
            chk("wait_addr", mem1.imem_addr, m_pc);
            chk("wait_req", 32'(mem1.imem_req), 32'd1);
            @(negedge clk);
        end
        chk("ack_addr", mem1.imem_addr, m_pc);
        chk("ack_addr_b", mem2.imem_addr, m_pc + OFF_B);
        chk("ack_req", 32'(mem1.imem_req), 32'd1);
        mem1.imem_ack = 1'b1; mem1.imem_rdata = word;
        @(negedge clk);
        mem1.imem_ack = 1'b0; mem1.imem_rdata = $urandom;
        chk("dec_req", 32'({mem1.imem_req, mem2.imem_req}), 32'd0);
        chk("dec_inst", inst1, word);
        chk("dec_alu", 32'(alu1), 32'd0);
        dec_we = we; dec_exc = exc;
        @(negedge clk);
        dec_we = 1'($urandom_range(0, 1)); dec_exc = 1'b0;
        if (exp_cause != 2'd0) begin
            chk("exc_halted", 32'({halted1, halted2}), 32'd3);
            chk("exc_cause", 32'(cause1), 32'(exp_cause));
            chk("exc_cause_b", 32'(cause2), 32'(exp_cause));
            chk("exc_pc", pc1, m_pc);
            chk("exc_strobes", 32'({mem1.imem_req, alu1, wr1, ret1}), 32'd0);
            return;
        end
        chk("ex_alu", 32'({alu1, alu2}), 32'd3);
        chk("ex_retired", 32'(ret1), 32'd0);
        // Spurious ack outside FETCH must not reach the instruction register.
        run = run_next; mem1.imem_ack = 1'b1; mem1.imem_rdata = ~word;
        @(negedge clk);
        mem1.imem_ack = 1'b0;
        chk("wb_retired", 32'({ret1, ret2}), 32'd3);
        chk("wb_wr", 32'(wr1), 32'(exp_wr));
        chk("wb_wr_b", 32'(wr2), 32'(exp_wr));
        chk("wb_alu", 32'(alu1), 32'd0);
        chk("wb_inst", inst1, word);
        chk("wb_inst_b", inst2, word);
        chk("wb_pc_old", pc1, m_pc);
        @(negedge clk);
        m_pc  = m_pc + 32'd4;
        m_cnt = m_cnt + 32'd1;
        chk("pc", pc1, m_pc);
        chk("pc_b", pc2, m_pc + OFF_B);
        chk("instret", instret1, m_cnt);
        chk("instret_b", instret2, m_cnt);
        chk("post_retired", 32'({ret1, wr1}), 32'd0);
        chk("next_req", 32'(mem1.imem_req), 32'(run_next));
        if (!run_next) begin
            repeat (2) @(negedge clk);
            chk("idle_req", 32'(mem1.imem_req), 32'd0);
            run = 1'b1;
        end
    endtask

    // ack_at = 0: never acknowledge; otherwise acknowledge in that FETCH cycle.
    task automatic do_timeout(input int ack_at);
        wait_req("tmo_start");
        for (int c = 1; c <= TMO; c++) begin
            chk("tmo_req", 32'(mem1.imem_req), 32'd1);
            chk("tmo_not_halted", 32'(halted1), 32'd0);
            if (c == ack_at) begin
                mem1.imem_ack = 1'b1; mem1.imem_rdata = 32'h2002_0005;
            end
            @(negedge clk);
            mem1.imem_ack = 1'b0;
            if (c == ack_at) break;
        end
        if (ack_at == 0) begin
            chk("tmo_halted", 32'(halted1), 32'd1);
            chk("tmo_cause", 32'(cause1), 32'd2);
            chk("tmo_req_off", 32'(mem1.imem_req), 32'd0);
        end else begin
            chk("late_ack_halted", 32'(halted1), 32'd0);
            chk("late_ack_inst", inst1, 32'h2002_0005);
            chk("late_ack_req_off", 32'(mem1.imem_req), 32'd0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        tbl[0] = '{0, 32'h0109_5020, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0};
        tbl[1] = '{5, 32'h8D09_0004, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0};
        tbl[2] = '{2, 32'hAD09_0008, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
        tbl[3] = '{0, 32'h1109_0003, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[4] = '{1, 32'h2129_FFFF, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0};
        tbl[5] = '{0, 32'h0109_5001, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1};
        mem1.imem_ack = 1'b0;
        mem1.imem_rdata = 32'd0;

        do_reset();
        @(negedge clk);
        chk("first_req", 32'(mem1.imem_req), 32'd1);
        chk("first_addr", mem1.imem_addr, PC0);
        chk("first_halted", 32'(halted1), 32'd0);

        for (int i = 0; i < 5; i++) begin
            do_instr(tbl[i].waits, tbl[i].word, tbl[i].we, tbl[i].exc,
                     tbl[i].run_next, tbl[i].exp_wr, tbl[i].exp_cause);
        end

        for (int i = 0; i < 30; i++) begin
            logic we_r;
            logic run_r;
            we_r  = 1'($urandom_range(0, 1));
            run_r = ($urandom_range(0, 4) != 0);
            do_instr(int'($urandom_range(0, 6)), $urandom, we_r, 1'b0, run_r, we_r, 2'd0);
        end

        do_instr(tbl[5].waits, tbl[5].word, tbl[5].we, tbl[5].exc,
                 tbl[5].run_next, tbl[5].exp_wr, tbl[5].exp_cause);
        chk("exc_funct", 32'(inst_funct(inst1)), 32'h01);
        chk("exc_opcode", 32'(inst_opcode(inst1)), 32'h00);
        for (int i = 0; i < 5; i++) begin
            mem1.imem_ack = 1'b1;
            @(negedge clk);
            mem1.imem_ack = 1'b0;
            chk("halt_sticky", 32'({halted1, cause1, mem1.imem_req, ret1}), 32'b1_01_0_0);
            chk("halt_instret", instret1, m_cnt);
        end

        do_reset();
        do_timeout(0);
        repeat (3) @(negedge clk);
        chk("tmo_sticky", 32'({halted1, cause1}), 32'b1_10);

        do_reset();
        do_timeout(TMO);

        do_reset();
        do_instr(0, 32'h0109_5020, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0);
        chk("wrap_pc_b", pc2, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
